// File: rtl/johnson_ring_ctr.sv
// Johnson / one-hot ring phase counter.
// Runtime-selectable sequence with enable, direction and synchronous load.
// Illegal states are detected and replaced by the seed of the current mode.
// A binary phase index and registered wrap / error pulses are exported.
module johnson_ring_ctr #(
    parameter int WIDTH      = 4,
    parameter int RESET_MODE = 0,
    parameter int PW         = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    localparam logic          RST_MODE = (RESET_MODE != 0) ? 1'b1 : 1'b0;
    localparam logic [PW:0]   TWO_W    = (PW+1)'(2*WIDTH);
    localparam logic [PW-1:0] LAST_J   = PW'(2*WIDTH-1);
    localparam logic [PW-1:0] LAST_R   = PW'(WIDTH-1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             cur_legal_s;
    logic [PW-1:0]    last_phase_s;

    // Starting pattern of a mode: all zeros (Johnson) or LSB set (ring).
    function automatic logic [WIDTH-1:0] seed_of(input logic m);
        logic [WIDTH-1:0] s;
        if (m) begin
            s = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            s = '0;
        end
        return s;
    endfunction

    // Number of set bits.
    function automatic logic [PW:0] popcount(input logic [WIDTH-1:0] v);
        logic [PW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{PW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Number of adjacent-bit transitions; a Johnson code has at most one.
    function automatic logic [PW:0] edge_count(input logic [WIDTH-1:0] v);
        logic [PW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH-1; i++) begin
            c = c + {{PW{1'b0}}, (v[i] ^ v[i+1])};
        end
        return c;
    endfunction

    // Legality of a pattern for the given mode.
    function automatic logic is_legal(input logic m, input logic [WIDTH-1:0] v);
        logic ok;
        if (m) begin
            ok = (popcount(v) == (PW+1)'(1));
        end else begin
            ok = (edge_count(v) <= (PW+1)'(1));
        end
        return ok;
    endfunction

    // Binary phase of a pattern; illegal patterns decode to zero.
    function automatic logic [PW-1:0] phase_of(input logic m, input logic [WIDTH-1:0] v);
        logic [PW-1:0] p;
        logic [PW:0]   pc;
        p  = '0;
        pc = popcount(v);
        if (!is_legal(m, v)) begin
            p = '0;
        end else if (m) begin
            for (int i = 0; i < WIDTH; i++) begin
                p = v[i] ? PW'(i) : p;
            end
        end else if (v[0] || (v == '0)) begin
            p = pc[PW-1:0];
        end else begin
            p = PW'(TWO_W - pc);
        end
        return p;
    endfunction

    // One step of the selected sequence in the selected direction.
    function automatic logic [WIDTH-1:0] step_of(input logic m, input logic d,
                                                 input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        case ({m, d})
            2'b00:   n = {~v[0], v[WIDTH-1:1]};
            2'b01:   n = {v[WIDTH-2:0], ~v[WIDTH-1]};
            2'b10:   n = {v[0], v[WIDTH-1:1]};
            2'b11:   n = {v[WIDTH-2:0], v[WIDTH-1]};
            default: n = v;
        endcase
        return n;
    endfunction

    assign out          = out_q;
    assign wrap         = wrap_q;
    assign err          = err_q;
    assign phase        = phase_of(mode_q, out_q);
    assign cur_legal_s  = is_legal(mode_q, out_q);
    assign last_phase_s = mode_q ? LAST_R : LAST_J;

    // Next state: mode change, then recovery, then load, then step, else hold.
    always_comb begin
        out_d  = out_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (mode != mode_q) begin
            out_d  = seed_of(mode);
            mode_d = mode;
        end else if (!cur_legal_s) begin
            out_d = seed_of(mode_q);
            err_d = 1'b1;
        end else if (load) begin
            if (is_legal(mode_q, load_val)) begin
                out_d = load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            out_d  = step_of(mode_q, dir, out_q);
            wrap_d = dir ? (phase == last_phase_s) : (phase == '0);
        end else begin
            out_d = out_q;
        end
    end

    // State and pulse registers with asynchronous return to the reset seed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q  <= seed_of(RST_MODE);
            mode_q <= RST_MODE;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_johnson_ring_ctr.sv
// Self-checking bench for johnson_ring_ctr (WIDTH = 4, RESET_MODE = 0).
module tb_johnson_ring_ctr;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'b0000;
    logic [3:0] out;
    logic [2:0] phase;
    logic       wrap, err;

    int checks = 0;
    int errors = 0;

    johnson_ring_ctr #(.WIDTH(4), .RESET_MODE(0)) dut (
        .clk(clk), .rstn(rstn), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_val(load_val), .out(out), .phase(phase), .wrap(wrap), .err(err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic en, dir, mode, load;
        logic [3:0] lv;
        logic [3:0] eo;
        int ep;
        logic ew, ee;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic d, input logic m, input logic l,
                       input logic [3:0] lv, input logic [3:0] eo, input int ep,
                       input logic ew, input logic ee);
        vec_t v;
        v.en = e; v.dir = d; v.mode = m; v.load = l; v.lv = lv;
        v.eo = eo; v.ep = ep; v.ew = ew; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pattern of phase p, computed from the sequence definition.
    function automatic logic [3:0] pat(input int md, input int p);
        logic [3:0] r;
        if (md == 1)      r = 4'(1 << p);
        else if (p <= W)  r = 4'((1 << p) - 1);
        else              r = 4'(((1 << W) - 1) ^ ((1 << (p - W)) - 1));
        return r;
    endfunction

    function automatic int seq_len(input int md);
        return (md == 1) ? W : 2*W;
    endfunction

    function automatic int find_phase(input int md, input logic [3:0] v);
        int r;
        r = -1;
        for (int p = 0; p < seq_len(md); p++) begin
            if (pat(md, p) == v) r = p;
        end
        return r;
    endfunction

    int m_mode, m_ph, idx, n;
    logic m_wrap, m_err;

    initial begin
        // Reset held two cycles.
        rstn = 1'b0;
        tick(); tick();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed table: counting, reversal, mode switch, loads.
        add(1,1,0,0,4'h0, 4'b0001,1,0,0);
        add(1,1,0,0,4'h0, 4'b0011,2,0,0);
        add(1,1,0,0,4'h0, 4'b0111,3,0,0);
        add(1,1,0,0,4'h0, 4'b1111,4,0,0);
        add(1,1,0,0,4'h0, 4'b1110,5,0,0);
        add(1,1,0,0,4'h0, 4'b1100,6,0,0);
        add(1,1,0,0,4'h0, 4'b1000,7,0,0);
        add(1,1,0,0,4'h0, 4'b0000,0,1,0);
        add(1,1,0,0,4'h0, 4'b0001,1,0,0);
        add(1,0,0,0,4'h0, 4'b0000,0,0,0);
        add(1,0,0,0,4'h0, 4'b1000,7,1,0);
        add(1,0,0,0,4'h0, 4'b1100,6,0,0);
        add(1,1,0,0,4'h0, 4'b1000,7,0,0);
        add(1,1,0,0,4'h0, 4'b0000,0,1,0);
        add(1,1,0,0,4'h0, 4'b0001,1,0,0);
        add(1,1,0,0,4'h0, 4'b0011,2,0,0);
        add(1,1,0,0,4'h0, 4'b0111,3,0,0);
        add(1,1,1,0,4'h0, 4'b0001,0,0,0);
        add(1,1,1,0,4'h0, 4'b0010,1,0,0);
        add(1,1,1,0,4'h0, 4'b0100,2,0,0);
        add(1,1,1,0,4'h0, 4'b1000,3,0,0);
        add(1,1,1,0,4'h0, 4'b0001,0,1,0);
        add(1,0,1,0,4'h0, 4'b1000,3,1,0);
        add(0,0,0,0,4'h0, 4'b0000,0,0,0);
        add(0,0,0,0,4'h0, 4'b0000,0,0,0);
        add(0,0,0,1,4'b0110, 4'b0000,0,0,1);
        add(0,0,0,1,4'b1100, 4'b1100,6,0,0);
        add(1,1,0,1,4'b0011, 4'b0011,2,0,0);
        add(0,1,0,0,4'h0, 4'b0011,2,0,0);

        foreach (tbl[i]) begin
            en = tbl[i].en; dir = tbl[i].dir; mode = tbl[i].mode;
            load = tbl[i].load; load_val = tbl[i].lv;
            tick();
            chk($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].eo));
            chk($sformatf("tbl%0d_phase", i), 32'(phase), 32'(tbl[i].ep));
            chk($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].ew));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].ee));
        end

        // Illegal state planted directly into the state register.
        en = 1'b0; load = 1'b0; mode = 1'b0;
        @(negedge clk);
        dut.out_q = 4'b0101;
        #1;
        chk("ill_phase", 32'(phase), 32'h0);
        tick();
        chk("ill_out", 32'(out), 32'h0);
        chk("ill_err", 32'(err), 32'h1);
        tick();
        chk("ill_err_clear", 32'(err), 32'h0);

        // Asynchronous reset mid-sequence at out = 1110.
        en = 1'b1; dir = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_rst_out", 32'(out), 32'b1110);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_out", 32'(out), 32'h0);
        chk("async_rst_wrap", 32'(wrap), 32'h0);
        chk("async_rst_err", 32'(err), 32'h0);
        tick();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_rst_phase", 32'(phase), 32'h0);
        tick();
        chk("resume_out", 32'(out), 32'b0001);
        chk("resume_phase", 32'(phase), 32'h1);

        // Randomized run against the phase-level reference model.
        en = 1'b0; mode = 1'b0; load = 1'b0;
        rstn = 1'b0;
        tick();
        @(negedge clk);
        rstn = 1'b1;
        m_mode = 0; m_ph = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            en   = ($urandom_range(0, 3) != 0);
            dir  = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                load_val = pat(int'(mode), int'($urandom_range(0, 2*W-1)) % seq_len(int'(mode)));
            end else begin
                load_val = 4'($urandom);
            end
            m_wrap = 1'b0; m_err = 1'b0;
            n = seq_len(m_mode);
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode);
                m_ph = 0;
            end else if (load) begin
                idx = find_phase(m_mode, load_val);
                if (idx >= 0) m_ph = idx;
                else m_err = 1'b1;
            end else if (en) begin
                if (dir) begin
                    m_wrap = (m_ph == n - 1);
                    m_ph = (m_ph + 1) % n;
                end else begin
                    m_wrap = (m_ph == 0);
                    m_ph = (m_ph + n - 1) % n;
                end
            end
            tick();
            chk("rnd_out", 32'(out), 32'(pat(m_mode, m_ph)));
            chk("rnd_phase", 32'(phase), 32'(m_ph));
            chk("rnd_wrap", 32'(wrap), 32'(m_wrap));
            chk("rnd_err", 32'(err), 32'(m_err));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/johnson_ring_ctr.md
Name: johnson_ring_ctr

Overview:
- Parametrised successor to the team's fixed-width Johnson counter.
- Runtime-selectable Johnson (twisted-ring) or one-hot ring sequence, with enable, up/down direction and synchronous parallel load.
- Detects and recovers from illegal states, and exports a binary phase index plus a wrap pulse.
- Used as a phase generator and clock-enable sequencer in timing and control paths.

Parameters:
- WIDTH, 4, number of state bits; must be 2 or more.
- RESET_MODE, 0, mode after reset: 0 = Johnson, 1 = ring.
- PW, $clog2(2*WIDTH), phase index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  step enable.
- dir  in  1  direction: 1 = up (shift toward MSB), 0 = down.
- mode  in  1  0 = Johnson, 1 = ring.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- out  out  WIDTH  counter state (registered).
- phase  out  PW  binary phase index (combinational decode of out).
- wrap  out  1  one-cycle pulse marking a sequence wrap (registered).
- err  out  1  one-cycle pulse marking an illegal state or rejected load (registered).

Behaviour:
- Seed value:
  - Johnson seed = all zeros.
  - Ring seed = 1 (LSB set).
- Reset (rstn = 0, asynchronous):
  - out = seed of RESET_MODE.
  - mode_q = RESET_MODE.
  - wrap = 0, err = 0.
- Step rules:
  - Johnson up: out <= {out[W-2:0], ~out[W-1]}.
  - Johnson down: out <= {~out[0], out[W-1:1]}.
  - Ring up: out <= {out[W-2:0], out[W-1]}.
  - Ring down: out <= {out[0], out[W-1:1]}.
- Legal states:
  - Johnson: a contiguous run of ones anchored at LSB (0…01…1) or at MSB (1…10…0), including all-zeros and all-ones; 2W states.
  - Ring: exactly one bit set; W states.
- Per-edge priority, highest first:
  1. Mode change (mode != mode_q): out <= seed of the new mode; mode_q <= mode; wrap = 0; err = 0.
  2. Illegal current state: out <= seed of mode_q; err pulses 1 for one cycle; en and load are ignored.
  3. load = 1:
     - load_val legal for mode_q: out <= load_val.
     - load_val illegal: out holds and err pulses.
     - No step and no wrap in either case.
  4. en = 1: step in direction dir.
  5. Otherwise: hold.
- Phase decode:
  - Johnson: if out[0] = 1 or out = 0, phase = popcount(out); else phase = 2W − popcount(out). Up sequence for W = 4: 0000 → 0001 → 0011 → 0111 → 1111 → 1110 → 1100 → 1000 = phases 0..7.
  - Ring: phase = index of the set bit.
  - Illegal state: phase = 0.
- Wrap: registered 1 for exactly the cycle after a step that moves
  - up from the last phase (2W−1 Johnson, W−1 ring) to phase 0, or
  - down from phase 0 to the last phase.
  - Mode change, recovery and load never assert wrap.
- Pulse width: wrap and err are 0 in every cycle not named above, so they never stretch.
- dir and mode may change on any cycle; they take effect at the next edge.
- Reset asserted mid-sequence returns to the seed immediately, without waiting for a clock edge.

Test Plan (WIDTH = 4, RESET_MODE = 0):
1. Reset held 2 cycles, then en = 1, dir = 1 for 9 edges:
   - out = 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
   - phase = 0..7, then 0, then 1.
   - wrap = 1 only in the cycle where out returns to 0000.
2. From out = 0000, dir = 0, en = 1:
   - out = 1000, then 1100.
   - wrap pulses in the cycle out = 1000.
   - phase = 7, then 6.
3. mode = 1 mid-count (out = 0111):
   - next edge: out = 0001, no wrap, no err.
   - up steps: 0010, 0100, 1000, 0001; wrap pulses on the return to 0001.
   - dir = 0 from 0001 gives 1000 with a wrap pulse.
4. Johnson mode:
   - load = 1, load_val = 0110 (illegal): out unchanged, err = 1 for one cycle.
   - load_val = 1100: out = 1100, phase = 6, no wrap.
   - load together with en: the load wins.
5. Illegal state forced via load bypass (force/deposit out = 0101):
   - next edge: out = 0000 and err = 1 for one cycle, even with en = 0.
   - following cycle: err = 0.
6. Reset mid-sequence:
   - rstn falls asynchronously between edges while out = 1110.
   - out = 0000, wrap = 0, err = 0 before the next clk edge.
   - after rstn rises, counting resumes from phase 0.
